// File: rtl/gp_regfile_pkg.sv
// gp_regfile_pkg: shared constants and the bulk-clear FSM state encoding
// for the general-purpose register file.
package gp_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clrState_t;

endpackage

// File: rtl/gp_regfile_clr_ctl.sv
// gp_regfile_clr_ctl: bulk-clear sequencer. On a request it walks a counter
// over every entry (one per cycle), then raises a one-cycle done pulse.
// Requests arriving while a clear is underway are ignored.
module gp_regfile_clr_ctl
  import gp_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clrReq,
  output logic              clrWe,
  output logic [ADDR_W-1:0] clrAddr,
  output logic              clrBusy,
  output logic              clrDone,
  output logic              fsmIdle
);

  localparam logic [ADDR_W-1:0] CNT_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  clrState_t         state_r;
  logic [ADDR_W-1:0] cnt_r;

  // Clear FSM, counter and registered status flags; the counter is parked
  // at zero on the last entry so it never wraps inside one clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      clrBusy <= 1'b0;
      clrDone <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          clrDone <= 1'b0;
          if (clrReq) begin
            state_r <= CLEAR;
            cnt_r   <= CNT_ZERO;
            clrBusy <= 1'b1;
          end else begin
            clrBusy <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt_r == LAST_ADDR) begin
            state_r <= DONE;
            cnt_r   <= CNT_ZERO;
            clrBusy <= 1'b0;
            clrDone <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          clrBusy <= 1'b0;
          clrDone <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          clrBusy <= 1'b0;
          clrDone <= 1'b0;
        end
      endcase
    end
  end

  assign clrWe   = (state_r == CLEAR);
  assign clrAddr = cnt_r;
  assign fsmIdle = (state_r == IDLE);

endmodule

// File: rtl/gp_regfile.sv
// gp_regfile: DEPTH x DATA_W register file, two combinational read ports,
// one write port, optional hardwired-zero entry 0 and a bulk-clear engine.
// Optional feature macro: GP_REGFILE_BYPASS_EN forwards same-cycle write
// data to a read port addressing the entry being written (IDLE only).
module gp_regfile
  import gp_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rAddr1,
  output logic [DATA_W-1:0] rDout1,
  input  logic [ADDR_W-1:0] rAddr2,
  output logic [DATA_W-1:0] rDout2,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wDin,
  input  logic              wEna,
  input  logic              clrReq,
  output logic              clrBusy,
  output logic              clrDone
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam bit                ZERO_EN   = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              clrWe_s;
  logic [ADDR_W-1:0] clrAddr_s;
  logic              fsmIdle_s;
  logic              wrOk_s;
  logic              isZero1_s;
  logic              isZero2_s;
  logic              bypHit1_s;
  logic              bypHit2_s;

  gp_regfile_clr_ctl #(
    .ADDR_W (ADDR_W)
  ) u_clrCtl (
    .clk     (clk),
    .rst     (rst),
    .clrReq  (clrReq),
    .clrWe   (clrWe_s),
    .clrAddr (clrAddr_s),
    .clrBusy (clrBusy),
    .clrDone (clrDone),
    .fsmIdle (fsmIdle_s)
  );

  // User writes only land while the clear engine is idle; entry 0 is
  // never written when it is hardwired to zero.
  assign wrOk_s    = fsmIdle_s & wEna & ~(ZERO_EN & (wAddr == ADDR_ZERO));
  assign isZero1_s = ZERO_EN & (rAddr1 == ADDR_ZERO);
  assign isZero2_s = ZERO_EN & (rAddr2 == ADDR_ZERO);

`ifdef GP_REGFILE_BYPASS_EN
  assign bypHit1_s = fsmIdle_s & wEna & (rAddr1 == wAddr);
  assign bypHit2_s = fsmIdle_s & wEna & (rAddr2 == wAddr);
`else
  assign bypHit1_s = 1'b0;
  assign bypHit2_s = 1'b0;
`endif

  // Storage: async reset zeroes everything; the clear engine has priority
  // over (and blocks) user writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
    end else if (clrWe_s) begin
      mem_r[clrAddr_s] <= DATA_ZERO;
    end else if (wrOk_s) begin
      mem_r[wAddr] <= wDin;
    end
  end

  // Read port 1: hardwired zero first, then forwarding, then storage.
  always_comb begin
    rDout1 = DATA_ZERO;
    if (isZero1_s) begin
      rDout1 = DATA_ZERO;
    end else if (bypHit1_s) begin
      rDout1 = wDin;
    end else begin
      rDout1 = mem_r[rAddr1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rDout2 = DATA_ZERO;
    if (isZero2_s) begin
      rDout2 = DATA_ZERO;
    end else if (bypHit2_s) begin
      rDout2 = wDin;
    end else begin
      rDout2 = mem_r[rAddr2];
    end
  end

endmodule

// File: doc/gp_regfile.md
GP_REGFILE -- requirements
Module: gp_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, setting the register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, setting the address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port rAddr1, input, ADDR_W bits: read port 1 address.
REQ-007 The block SHALL have port rDout1, output, DATA_W bits: read port 1 data, combinational.
REQ-008 The block SHALL have port rAddr2, input, ADDR_W bits: read port 2 address.
REQ-009 The block SHALL have port rDout2, output, DATA_W bits: read port 2 data, combinational.
REQ-010 The block SHALL have port wAddr, input, ADDR_W bits: write address.
REQ-011 The block SHALL have port wDin, input, DATA_W bits: write data.
REQ-012 The block SHALL have port wEna, input, 1 bit: write enable.
REQ-013 The block SHALL have port clrReq, input, 1 bit: bulk-clear request, sampled on clk.
REQ-014 The block SHALL have port clrBusy, output, 1 bit: high while a bulk clear is in progress.
REQ-015 The block SHALL have port clrDone, output, 1 bit: one-cycle pulse when a bulk clear completes.

Function
REQ-016 The block SHALL write wDin into entry wAddr on a rising clk edge when wEna=1 and the FSM is IDLE.
REQ-017 Reads SHALL be combinational from stored contents; without bypass, written data SHALL be visible after the write edge.
REQ-018 With ZERO_REG=1, reads of address 0 SHALL return 0, writes to address 0 SHALL be discarded, and bypass SHALL never apply to address 0.
REQ-019 The clear FSM SHALL have states IDLE, CLEAR and DONE.
REQ-020 In IDLE, clrReq=1 SHALL move the FSM to CLEAR with clear counter 0; clrBusy SHALL rise in the following cycle.
REQ-021 In CLEAR, each cycle SHALL zero the entry at the counter and increment the counter; after entry DEPTH-1 is zeroed, the FSM SHALL go to DONE. The clear SHALL take exactly DEPTH cycles.
REQ-022 In DONE, clrDone=1 and clrBusy=0 SHALL hold for one cycle, then the FSM SHALL return to IDLE.
REQ-023 clrBusy SHALL be 1 only in CLEAR.
REQ-024 wEna SHALL be ignored in CLEAR and DONE, so the write is dropped; clrReq SHALL be ignored in CLEAR and DONE.
REQ-025 During CLEAR, reads SHALL return 0 for entries already cleared and the old contents for entries not yet cleared.
REQ-026 A clrReq arriving in the same IDLE cycle as wEna SHALL let the write complete on that edge; the clear then starts and erases that written entry.
REQ-027 The counter SHALL be ADDR_W bits wide and SHALL not wrap within one clear.

Reset
REQ-028 While rst=1, regardless of clk, all entries SHALL be 0, the FSM SHALL be IDLE, the counter 0, clrBusy=0 and clrDone=0.
REQ-029 Reset asserted mid-clear SHALL abort the clear immediately with no clrDone pulse.
REQ-030 After reset, rDout1 and rDout2 SHALL read 0 for every address.

Configuration
REQ-031 When macro GP_REGFILE_BYPASS_EN is defined, and FSM=IDLE, wEna=1, and rAddrN=wAddr (excluding hardwired zero), rDoutN SHALL equal wDin in the same cycle.
REQ-032 When GP_REGFILE_BYPASS_EN is undefined, there SHALL be no forwarding and reads SHALL return stored contents only.

Structure
REQ-033 The package gp_regfile_pkg SHALL hold the FSM state encodings (IDLE, CLEAR, DONE) and the default DATA_W and ADDR_W constants.
REQ-034 The clear FSM and counter SHALL be sub-module gp_regfile_clr_ctl, which outputs the clear-write enable, the clear address, clrBusy and clrDone.

Verification
REQ-035 Write then read: write 0xDEADBEEF to addr 7, then on the next cycle set rAddr1=7 -> rDout1=0xDEADBEEF; addr 0 written with 0x1234 -> rDout2=0.
REQ-036 Bypass: wEna=1, wAddr=rAddr1=3, wDin=0xA5A5A5A5, old value 0 -> with the macro, rDout1=0xA5A5A5A5 in the same cycle; without it, rDout1=0 until the edge.
REQ-037 Bulk clear: fill all 32 entries with nonzero data, pulse clrReq -> clrBusy high for exactly 32 cycles, one clrDone pulse, then all entries read 0.
REQ-038 Write during clear: wEna=1 to addr 31 on clear cycle 5 -> the write is dropped and addr 31 reads 0 after clrDone.
REQ-039 Reset mid-clear: assert rst on clear cycle 10 -> all entries are 0 and clrBusy=0 asynchronously, with no clrDone pulse.
REQ-040 Parameter sweep: DATA_W=16, ADDR_W=3 -> the clear takes 8 cycles and the write/read of 0xBEEF to addr 7 passes.
